// File: rtl/block_copy_dma.sv
// -----------------------------------------------------------------------------
// block_copy_dma
//
// Word-by-word block copy engine for a ROWS x COLS array of 64-bit words.
// A copy request (src, dst, length) is validated on start; accepted requests
// alternate one read cycle and one write cycle per word (2 cycles/word).
// Addresses are {row[63:32], col[31:0]} and advance column-first, wrapping
// into the next row at the end of each row.
//
// Ports
//   clk            in   clock, all state on posedge
//   rst            in   asynchronous active-high reset
//   start          in   one-cycle copy request (only honoured in IDLE)
//   src_addr       in   first source word {row, col}
//   dst_addr       in   first destination word {row, col}
//   length         in   number of words to copy
//   busy           out  transfer in progress (RD/WR/DONE)
//   done           out  one-cycle pulse on successful completion
//   error          out  one-cycle pulse on a rejected request
//   words_copied   out  words written in the current/last transfer
//   mem_address    out  word address to data memory (0 when idle)
//   mem_writeData  out  write data to data memory (0 unless writing)
//   mem_read       out  read strobe
//   mem_write      out  write strobe
//   mem_readData   in   read result, valid in the cycle after mem_read
// -----------------------------------------------------------------------------
module block_copy_dma #(
    parameter int ROWS = 32,
    parameter int COLS = 32,
    parameter int LW   = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [63:0]   src_addr,
    input  logic [63:0]   dst_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [LW-1:0] words_copied,
    output logic [63:0]   mem_address,
    output logic [63:0]   mem_writeData,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [63:0]   mem_readData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [63:0] TOTAL_WORDS = 64'(ROWS) * 64'(COLS);

    state_t        state_q;
    logic [63:0]   src_q;
    logic [63:0]   dst_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] words_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          rd_q;
    logic          wr_q;
    logic [63:0]   addr_q;

    // Next-word pointers and request check, computed combinationally
    logic [63:0]   src_next_d;
    logic [63:0]   dst_next_d;
    logic [LW-1:0] words_inc_d;
    logic          req_ok_d;

    // True when the whole range [a, a+len) lies inside the array.
    function automatic logic range_ok(input logic [63:0] a, input logic [LW-1:0] len);
        logic [63:0] lin;
        if (a[63:32] >= 32'(ROWS) || a[31:0] >= 32'(COLS)) begin
            return 1'b0;
        end
        lin = 64'(a[63:32]) * 64'(COLS) + 64'(a[31:0]);
        return (lin + 64'(len)) <= TOTAL_WORDS;
    endfunction

    // Column-first increment with wrap into the next row.
    function automatic logic [63:0] advance(input logic [63:0] a);
        if (a[31:0] == 32'(COLS - 1)) begin
            return {a[63:32] + 32'd1, 32'd0};
        end
        return {a[63:32], a[31:0] + 32'd1};
    endfunction

    always_comb begin
        src_next_d  = advance(src_q);
        dst_next_d  = advance(dst_q);
        words_inc_d = words_q + LW'(1);
        req_ok_d    = range_ok(src_addr, length) && range_ok(dst_addr, length);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            // Status pulses last exactly one cycle unless re-armed below
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        len_q   <= length;
                        words_q <= '0;
                        if (!req_ok_d) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end else if (length == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                            busy_q  <= 1'b1;
                            rd_q    <= 1'b1;
                            addr_q  <= src_addr;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_WR;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b1;
                    addr_q  <= dst_q;
                end
                S_WR: begin
                    wr_q    <= 1'b0;
                    words_q <= words_inc_d;
                    src_q   <= src_next_d;
                    dst_q   <= dst_next_d;
                    if (words_inc_d == len_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        state_q <= S_RD;
                        rd_q    <= 1'b1;
                        addr_q  <= src_next_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                end
            endcase
        end
    end

    // Read data only arrives in the write cycle, so the write data path is a
    // gated pass-through rather than a register.
    assign mem_writeData = wr_q ? mem_readData : 64'd0;
    assign mem_address   = addr_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_copied  = words_q;

endmodule

// File: tb/tb_block_copy_dma.sv
module tb_block_copy_dma;

    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [63:0]   src_addr = '0;
    logic [63:0]   dst_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy, done, error, mem_read, mem_write;
    logic [LW-1:0] words_copied;
    logic [63:0]   mem_address, mem_writeData, mem_readData;

    int tests_run = 0;
    int failures  = 0;

    // Bench data memory: 1-cycle read latency, 0 when not reading
    logic [63:0] mem [0:31][0:31];
    logic [63:0] rd_data = '0;
    logic        pre_we = 1'b0;
    logic [4:0]  pre_row = '0, pre_col = '0;
    logic [63:0] pre_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= '0;
        if (mem_read)  rd_data <= mem[mem_address[36:32]][mem_address[4:0]];
        if (mem_write) mem[mem_address[36:32]][mem_address[4:0]] <= mem_writeData;
        if (pre_we)    mem[pre_row][pre_col] <= pre_data;
    end
    assign mem_readData = rd_data;

    block_copy_dma #(.ROWS(32), .COLS(32), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .busy(busy), .done(done), .error(error),
        .words_copied(words_copied), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_read(mem_read), .mem_write(mem_write),
        .mem_readData(mem_readData)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int r, input int c, input logic [63:0] d);
        pre_we = 1'b1; pre_row = 5'(r); pre_col = 5'(c); pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Pulse start for one edge; on return the first post-start state is visible
    task automatic launch(input logic [63:0] s, input logic [63:0] d, input int len);
        src_addr = s; dst_addr = d; length = LW'(len); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests_run++; if ({busy, done, error, mem_read, mem_write} !== 5'b0) begin failures++; $display("FAIL reset_flags got %b exp 00000", {busy, done, error, mem_read, mem_write}); end
        tests_run++; if (mem_address !== 64'd0) begin failures++; $display("FAIL reset_addr got %h exp 0", mem_address); end
        tests_run++; if (words_copied !== '0) begin failures++; $display("FAIL reset_wc got %0d exp 0", words_copied); end
        tests_run++; if (mem_writeData !== 64'd0) begin failures++; $display("FAIL reset_wdata got %h exp 0", mem_writeData); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_copy();
        logic [63:0] ea, ed;
        for (int k = 0; k < 4; k++) poke(0, k, 64'hA0A0_0000_0000_0000 + 64'(k));
        for (int k = 0; k < 4; k++) poke(1, k, 64'hDEAD);
        launch({32'd0, 32'd0}, {32'd1, 32'd0}, 4);
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 1) begin
                ea = {32'd0, 32'((i - 1) / 2)};
                tests_run++; if ({mem_read, mem_write, done} !== 3'b100 || mem_address !== ea) begin failures++; $display("FAIL basic_rd%0d got rd=%b wr=%b dn=%b a=%h exp 1 0 0 a=%h", i, mem_read, mem_write, done, mem_address, ea); end
            end else begin
                ea = {32'd1, 32'((i - 2) / 2)};
                ed = 64'hA0A0_0000_0000_0000 + 64'((i - 2) / 2);
                tests_run++; if ({mem_read, mem_write, done} !== 3'b010 || mem_address !== ea || mem_writeData !== ed) begin failures++; $display("FAIL basic_wr%0d got rd=%b wr=%b dn=%b a=%h d=%h exp 0 1 0 a=%h d=%h", i, mem_read, mem_write, done, mem_address, mem_writeData, ea, ed); end
            end
            tick();
        end
        tests_run++; if (done !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_done got done=%b busy=%b exp 1 1", done, busy); end
        tests_run++; if (words_copied !== LW'(4)) begin failures++; $display("FAIL basic_wc got %0d exp 4", words_copied); end
        tests_run++; if ({mem_read, mem_write} !== 2'b00 || mem_address !== 64'd0) begin failures++; $display("FAIL basic_done_strobes got %b a=%h exp 00 a=0", {mem_read, mem_write}, mem_address); end
        tick();
        tests_run++; if (done !== 1'b0 || busy !== 1'b0 || words_copied !== LW'(4)) begin failures++; $display("FAIL basic_idle got done=%b busy=%b wc=%0d exp 0 0 4", done, busy, words_copied); end
        for (int k = 0; k < 4; k++) begin
            tests_run++; if (mem[1][k] !== 64'hA0A0_0000_0000_0000 + 64'(k)) begin failures++; $display("FAIL basic_mem%0d got %h exp %h", k, mem[1][k], 64'hA0A0_0000_0000_0000 + 64'(k)); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] ra [3];
        logic [63:0] wa [3];
        ra[0] = {32'd0, 32'd30}; ra[1] = {32'd0, 32'd31}; ra[2] = {32'd1, 32'd0};
        wa[0] = {32'd2, 32'd31}; wa[1] = {32'd3, 32'd0};  wa[2] = {32'd3, 32'd1};
        poke(0, 30, 64'h1111); poke(0, 31, 64'h2222); poke(1, 0, 64'h3333);
        launch(ra[0], wa[0], 3);
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (mem_read !== 1'b1 || mem_address !== ra[k]) begin failures++; $display("FAIL wrap_rd%0d got rd=%b a=%h exp 1 a=%h", k, mem_read, mem_address, ra[k]); end
            tick();
            tests_run++; if (mem_write !== 1'b1 || mem_address !== wa[k]) begin failures++; $display("FAIL wrap_wr%0d got wr=%b a=%h exp 1 a=%h", k, mem_write, mem_address, wa[k]); end
            tick();
        end
        tests_run++; if (done !== 1'b1 || words_copied !== LW'(3)) begin failures++; $display("FAIL wrap_done got done=%b wc=%0d exp 1 3", done, words_copied); end
        tick();
        tests_run++; if (mem[2][31] !== 64'h1111 || mem[3][0] !== 64'h2222 || mem[3][1] !== 64'h3333) begin failures++; $display("FAIL wrap_mem got %h %h %h exp 1111 2222 3333", mem[2][31], mem[3][0], mem[3][1]); end
    endtask

    task automatic test_reject();
        // Range runs off the end of the array
        launch({32'd31, 32'd31}, {32'd4, 32'd0}, 2);
        tests_run++; if ({error, done, mem_read, mem_write} !== 4'b1000) begin failures++; $display("FAIL rej_end got err/dn/rd/wr=%b exp 1000", {error, done, mem_read, mem_write}); end
        tests_run++; if (words_copied !== '0) begin failures++; $display("FAIL rej_end_wc got %0d exp 0", words_copied); end
        tick();
        tests_run++; if ({error, mem_read, mem_write} !== 3'b000) begin failures++; $display("FAIL rej_end_after got %b exp 000", {error, mem_read, mem_write}); end
        // Row out of range
        launch({32'd32, 32'd0}, {32'd4, 32'd0}, 1);
        tests_run++; if ({error, done, mem_read, mem_write} !== 4'b1000) begin failures++; $display("FAIL rej_row got err/dn/rd/wr=%b exp 1000", {error, done, mem_read, mem_write}); end
        tick();
        // Destination column out of range
        launch({32'd4, 32'd0}, {32'd4, 32'd32}, 1);
        tests_run++; if (error !== 1'b1 || mem_read !== 1'b0) begin failures++; $display("FAIL rej_dcol got err=%b rd=%b exp 1 0", error, mem_read); end
        tick();
        // Range ending exactly on the last word is legal
        launch({32'd31, 32'd30}, {32'd8, 32'd0}, 2);
        tests_run++; if (error !== 1'b0 || mem_read !== 1'b1) begin failures++; $display("FAIL edge_ok got err=%b rd=%b exp 0 1", error, mem_read); end
        for (int i = 0; i < 4; i++) tick();
        tests_run++; if (done !== 1'b1 || words_copied !== LW'(2)) begin failures++; $display("FAIL edge_done got done=%b wc=%0d exp 1 2", done, words_copied); end
        tick();
    endtask

    task automatic test_zero_length();
        launch({32'd0, 32'd0}, {32'd1, 32'd0}, 0);
        tests_run++; if ({done, error, mem_read, mem_write} !== 4'b1000) begin failures++; $display("FAIL zero_len got dn/err/rd/wr=%b exp 1000", {done, error, mem_read, mem_write}); end
        tests_run++; if (words_copied !== '0) begin failures++; $display("FAIL zero_len_wc got %0d exp 0", words_copied); end
        tick();
        tests_run++; if ({done, busy, mem_read, mem_write} !== 4'b0000) begin failures++; $display("FAIL zero_len_after got %b exp 0000", {done, busy, mem_read, mem_write}); end
    endtask

    task automatic test_reset_mid();
        int dn;
        for (int k = 0; k < 8; k++) poke(4, k, 64'hB000 + 64'(k));
        for (int k = 0; k < 8; k++) poke(5, k, 64'h5E5E);
        launch({32'd4, 32'd0}, {32'd5, 32'd0}, 8);
        for (int i = 0; i < 5; i++) tick();
        tests_run++; if (mem_write !== 1'b1 || mem_address !== {32'd5, 32'd2}) begin failures++; $display("FAIL mid_3rd_wr got wr=%b a=%h exp 1 a=%h", mem_write, mem_address, {32'd5, 32'd2}); end
        rst = 1'b1;
        #1;
        tests_run++; if ({busy, done, error, mem_read, mem_write} !== 5'b0 || mem_address !== 64'd0 || mem_writeData !== 64'd0 || words_copied !== '0) begin failures++; $display("FAIL mid_rst_outs got flags=%b a=%h d=%h wc=%0d exp 0", {busy, done, error, mem_read, mem_write}, mem_address, mem_writeData, words_copied); end
        tick();
        rst = 1'b0;
        tests_run++; if (mem[5][0] !== 64'hB000 || mem[5][1] !== 64'hB001 || mem[5][2] !== 64'h5E5E) begin failures++; $display("FAIL mid_mem got %h %h %h exp b000 b001 5e5e", mem[5][0], mem[5][1], mem[5][2]); end
        // First start right after reset release is accepted
        launch({32'd4, 32'd7}, {32'd5, 32'd7}, 1);
        tests_run++; if (mem_read !== 1'b1 || mem_address !== {32'd4, 32'd7}) begin failures++; $display("FAIL post_rst_start got rd=%b a=%h exp 1 a=%h", mem_read, mem_address, {32'd4, 32'd7}); end
        dn = 0;
        for (int i = 0; i < 3; i++) begin tick(); dn += int'(done); end
        tests_run++; if (dn !== 1 || mem[5][7] !== 64'hB007 || mem[5][2] !== 64'h5E5E) begin failures++; $display("FAIL post_rst_copy got dones=%0d m57=%h m52=%h exp 1 b007 5e5e", dn, mem[5][7], mem[5][2]); end
    endtask

    task automatic test_back_to_back();
        int dn, both, nrd, nwr, badaddr;
        for (int k = 0; k < 5; k++) poke(6, k, 64'hC000 + 64'(k));
        dn = 0; both = 0; nrd = 0; nwr = 0; badaddr = 0;
        launch({32'd6, 32'd0}, {32'd7, 32'd0}, 5);
        start = 1'b1;
        src_addr = '0; dst_addr = {32'd9, 32'd0}; length = LW'(2);
        for (int i = 1; i <= 13; i++) begin
            if (i == 10) start = 1'b0;
            dn += int'(done);
            if (mem_read && mem_write) both++;
            if (mem_read) begin
                nrd++;
                if (mem_address !== {32'd6, 32'((i - 1) / 2)}) badaddr++;
            end
            if (mem_write) begin
                nwr++;
                if (mem_address !== {32'd7, 32'((i - 2) / 2)}) badaddr++;
            end
            if (i == 11) begin
                tests_run++; if (done !== 1'b1 || words_copied !== LW'(5)) begin failures++; $display("FAIL b2b_done_cycle got done=%b wc=%0d exp 1 5", done, words_copied); end
            end
            tick();
        end
        tests_run++; if (dn !== 1) begin failures++; $display("FAIL b2b_dones got %0d exp 1", dn); end
        tests_run++; if (both !== 0) begin failures++; $display("FAIL b2b_overlap got %0d exp 0", both); end
        tests_run++; if (nrd !== 5 || nwr !== 5 || badaddr !== 0) begin failures++; $display("FAIL b2b_strobes got rd=%0d wr=%0d bad=%0d exp 5 5 0", nrd, nwr, badaddr); end
        for (int k = 0; k < 5; k++) begin
            tests_run++; if (mem[7][k] !== 64'hC000 + 64'(k)) begin failures++; $display("FAIL b2b_mem%0d got %h exp %h", k, mem[7][k], 64'hC000 + 64'(k)); end
        end
        tests_run++; if (busy !== 1'b0 || words_copied !== LW'(5)) begin failures++; $display("FAIL b2b_idle got busy=%b wc=%0d exp 0 5", busy, words_copied); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_wrap();
        test_reject();
        test_zero_length();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/block_copy_dma.md
BLOCK_COPY_DMA -- requirements
Module: block_copy_dma

Interface
REQ-001 Parameter ROWS, default 32, number of memory rows addressed by mem_address[63:32].
REQ-002 Parameter COLS, default 32, number of words per row addressed by mem_address[31:0].
REQ-003 Parameter LW, default 11, width of length/count fields (max length ROWS*COLS = 1024).
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-007 src_addr  in  64  first source word, {row[63:32], col[31:0]}.
REQ-008 dst_addr  in  64  first destination word, same format.
REQ-009 length  in  LW  number of 64-bit words to copy.
REQ-010 busy  out  1  high from the cycle after an accepted start until DONE state exits.
REQ-011 done  out  1  one-cycle pulse on successful completion.
REQ-012 error  out  1  one-cycle pulse on rejected request; no memory access made.
REQ-013 words_copied  out  LW  count of words written in current/last transfer.
REQ-014 mem_address  out  64  word address to data memory, {row, col}.
REQ-015 mem_writeData  out  64  write data to data memory.
REQ-016 mem_read  out  1  read strobe to data memory.
REQ-017 mem_write  out  1  write strobe to data memory.
REQ-018 mem_readData  in  64  data memory read result; valid only in the cycle after mem_read=1 (memory drives 0 otherwise).

Function
REQ-019 States: IDLE, RD, WR, DONE, ERR; the block SHALL hold exactly one state per cycle.
REQ-020 IDLE: on start=1, latch src, dst, length; words_copied<=0; go to ERR if rejected, DONE if length=0, else RD.
REQ-021 Rejection: any src/dst row>=ROWS or col>=COLS, or linear(src)+length>ROWS*COLS, or linear(dst)+length>ROWS*COLS, where linear={row*COLS+col}.
REQ-022 RD: mem_read=1, mem_write=0, mem_address=current src; next state WR.
REQ-023 WR: mem_write=1, mem_read=0, mem_address=current dst, mem_writeData=mem_readData; words_copied increments; src and dst each advance one word.
REQ-024 WR exit: DONE if words_copied+1=length, else RD; throughput SHALL be exactly 2 cycles per word.
REQ-025 Address advance: col+1; when col=COLS-1, col<=0 and row<=row+1.
REQ-026 DONE: done=1 for one cycle, then IDLE; ERR: error=1 for one cycle, then IDLE.
REQ-027 mem_read and mem_write SHALL never be high in the same cycle; both low in IDLE, DONE, ERR.
REQ-028 mem_address and mem_writeData SHALL be 0 when the corresponding strobe is low.
REQ-029 start while not IDLE SHALL be ignored; latched parameters SHALL not change mid-transfer.
REQ-030 Overlapping src/dst ranges are copied in ascending order; no overlap correction.
REQ-031 Total latency start to done pulse = 2*length+1 cycles (length=0: 1 cycle; reject: error pulse 1 cycle after start).
REQ-032 words_copied SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE and busy, done, error, mem_read, mem_write=0, mem_address, mem_writeData=0, words_copied=0.
REQ-034 Reset mid-transfer SHALL abort without completing the in-flight word; no done pulse.
REQ-035 After rst deasserts, the first start SHALL be accepted in the next cycle.

Verification
REQ-036 Preload M[0][0..3]=A0..A3; start src={0,0} dst={1,0} length=4 -> alternating RD/WR 8 cycles, M[1][0..3]=A0..A3, done pulse at cycle 9, words_copied=4.
REQ-037 src={0,30} dst={2,31} length=3 -> reads {0,30},{0,31},{1,0}; writes {2,31},{3,0},{3,1}.
REQ-038 length=0 -> no mem strobes, done one cycle after start; src={31,31} length=2 or src row=32 -> error pulse, no strobes, words_copied=0.
REQ-039 rst asserted during 3rd WR of length=8 copy -> all outputs 0 same cycle, words copied so far =2 in memory, no done.
REQ-040 start pulsed every cycle during a length=5 copy -> single transfer, one done pulse, strobes never simultaneously high.
